// File: rtl/cnt0_core.sv
// cnt0_core: prescaled up-counter feeding the CNT0 delay stage.
// Saturates at the data register in DLY mode, wraps in CNT mode.
module cnt0_core #(
  parameter int BIT_WIDTH = 14
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [2:0]           i_clk_div_select,
  input  logic                 i_mode,
  input  logic [BIT_WIDTH-1:0] i_data_from_register,
  input  logic                 i_cnt_reset_n,
  input  logic                 i_cnt_allow,
  output logic [BIT_WIDTH-1:0] o_counter,
  output logic                 o_tick,
  output logic                 o_terminal
);

  logic [2:0]           r_sel;
  logic [5:0]           r_div_cnt;
  logic [BIT_WIDTH-1:0] r_counter;
  logic                 r_terminal;

  logic [5:0]           w_nm1;
  logic                 w_sel_chg;
  logic                 w_tick;
  logic                 w_at_term;
  logic                 w_step;
  logic [BIT_WIDTH-1:0] w_inc;

  // Divider terminal value (N-1) for the requested prescale ratio
  always_comb begin
    w_nm1 = 6'd0;
    case (i_clk_div_select)
      3'd1:    w_nm1 = 6'd3;
      3'd2:    w_nm1 = 6'd11;
      3'd3:    w_nm1 = 6'd23;
      3'd4:    w_nm1 = 6'd63;
      default: w_nm1 = 6'd0;
    endcase
  end

  // A select change restarts the divider, so no tick from stale phase
  assign w_sel_chg = (i_clk_div_select != r_sel);
  assign w_tick    = w_sel_chg ? (w_nm1 == 6'd0)
                               : (r_div_cnt == w_nm1);
  assign w_at_term = (r_counter >= i_data_from_register);
  assign w_step    = w_tick & i_cnt_allow;
  assign w_inc     = r_counter + BIT_WIDTH'(1);

  // Prescaler: free-running divider, cleared by clear or select change
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sel     <= 3'd0;
      r_div_cnt <= 6'd0;
    end else begin
      r_sel <= i_clk_div_select;
      if (!i_cnt_reset_n || w_sel_chg || w_tick)
        r_div_cnt <= 6'd0;
      else
        r_div_cnt <= r_div_cnt + 6'd1;
    end
  end

  // Counter and one-cycle terminal pulse
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_counter  <= '0;
      r_terminal <= 1'b0;
    end else if (!i_cnt_reset_n) begin
      r_counter  <= '0;
      r_terminal <= 1'b0;
    end else begin
      r_terminal <= 1'b0;
      if (w_step && !w_at_term) begin
        r_counter  <= w_inc;
        r_terminal <= !i_mode &&
                      (w_inc == i_data_from_register);
      end else if (w_step && i_mode) begin
        r_counter  <= '0;
        r_terminal <= 1'b1;
      end
    end
  end

  assign o_counter  = r_counter;
  assign o_tick     = w_tick;
  assign o_terminal = r_terminal;

endmodule

// File: tb/tb_cnt0_core.sv
// tb_cnt0_core: directed scoreboard bench for cnt0_core.
// Expected count/terminal/tick are queued per step, checked after the edge.
module tb_cnt0_core;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [2:0]  i_clk_div_select = 3'd0;
  logic        i_mode = 1'b0;
  logic [13:0] i_data_from_register = 14'd5;
  logic        i_cnt_reset_n = 1'b1;
  logic        i_cnt_allow = 1'b1;
  logic [13:0] o_counter;
  logic        o_tick;
  logic        o_terminal;

  typedef struct packed {
    logic [13:0] cnt;
    logic        term;
    logic        tick;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  cnt0_core #(.BIT_WIDTH(14)) dut (
    .i_clk                (i_clk),
    .i_reset              (i_reset),
    .i_clk_div_select     (i_clk_div_select),
    .i_mode               (i_mode),
    .i_data_from_register (i_data_from_register),
    .i_cnt_reset_n        (i_cnt_reset_n),
    .i_cnt_allow          (i_cnt_allow),
    .o_counter            (o_counter),
    .o_tick               (o_tick),
    .o_terminal           (o_terminal)
  );

  always #5 i_clk = ~i_clk;

  task automatic push(input logic [13:0] c, input logic t,
                      input logic k);
    exp_t e;
    e.cnt  = c;
    e.term = t;
    e.tick = k;
    q.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = q.pop_front();
    assert (o_counter === e.cnt) else begin
      errors++;
      $error("FAIL %s cnt: got %0d exp %0d", tag, o_counter, e.cnt);
    end
    checks++;
    assert (o_terminal === e.term) else begin
      errors++;
      $error("FAIL %s term: got %b exp %b", tag, o_terminal, e.term);
    end
    checks++;
    assert (o_tick === e.tick) else begin
      errors++;
      $error("FAIL %s tick: got %b exp %b", tag, o_tick, e.tick);
    end
  endtask

  task automatic edge_chk(input string tag, input logic [13:0] c,
                          input logic t, input logic k);
    push(c, t, k);
    @(posedge i_clk);
    #1;
    pop_chk(tag);
  endtask

  initial begin
    int c;
    // reset state
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    push(14'd0, 1'b0, 1'b1);
    pop_chk("reset");
    i_reset = 1'b0;

    // div1 DLY count to 5 and hold
    for (int k = 1; k <= 7; k++)
      edge_chk("dly1", (k > 5) ? 14'd5 : 14'(k), k == 5, 1'b1);

    // div4 CNT wrap at 3
    i_cnt_reset_n = 1'b0;
    i_clk_div_select = 3'd1;
    i_mode = 1'b1;
    i_data_from_register = 14'd3;
    edge_chk("clr4", 14'd0, 1'b0, 1'b0);
    i_cnt_reset_n = 1'b1;
    for (int k = 1; k <= 32; k++)
      edge_chk("cnt4", 14'((k / 4) % 4), (k % 16) == 0,
               (k % 4) == 3);

    // clear beats step
    i_cnt_reset_n = 1'b0;
    i_clk_div_select = 3'd0;
    i_mode = 1'b0;
    i_data_from_register = 14'd100;
    edge_chk("clr1", 14'd0, 1'b0, 1'b1);
    i_cnt_reset_n = 1'b1;
    for (int k = 1; k <= 7; k++)
      edge_chk("run7", 14'(k), 1'b0, 1'b1);
    i_cnt_reset_n = 1'b0;
    edge_chk("clrstep", 14'd0, 1'b0, 1'b1);
    i_cnt_reset_n = 1'b1;
    for (int k = 1; k <= 3; k++)
      edge_chk("resume", 14'(k), 1'b0, 1'b1);

    // div12 allow gating
    i_cnt_reset_n = 1'b0;
    i_clk_div_select = 3'd2;
    edge_chk("clr12", 14'd0, 1'b0, 1'b0);
    i_cnt_reset_n = 1'b1;
    c = 0;
    for (int k = 1; k <= 62; k++) begin
      i_cnt_allow = !(k > 26 && k <= 56);
      if ((k % 12) == 0 && i_cnt_allow) c++;
      edge_chk("gate", 14'(c), 1'b0, (k % 12) == 11);
    end
    i_cnt_allow = 1'b1;

    // data lowered below count
    i_cnt_reset_n = 1'b0;
    i_clk_div_select = 3'd0;
    edge_chk("clr50", 14'd0, 1'b0, 1'b1);
    i_cnt_reset_n = 1'b1;
    for (int k = 1; k <= 50; k++)
      edge_chk("to50", 14'(k), 1'b0, 1'b1);
    i_data_from_register = 14'd20;
    for (int k = 0; k < 3; k++)
      edge_chk("lowdly", 14'd50, 1'b0, 1'b1);
    i_mode = 1'b1;
    edge_chk("lowcnt", 14'd0, 1'b1, 1'b1);
    edge_chk("aftwrap", 14'd1, 1'b0, 1'b1);

    // async reset while terminal pulse is high
    i_cnt_reset_n = 1'b0;
    i_mode = 1'b0;
    i_data_from_register = 14'd9;
    edge_chk("clr9", 14'd0, 1'b0, 1'b1);
    i_cnt_reset_n = 1'b1;
    for (int k = 1; k <= 9; k++)
      edge_chk("to9", 14'(k), k == 9, 1'b1);
    #3;
    i_reset = 1'b1;
    i_clk_div_select = 3'd4;
    #1;
    push(14'd0, 1'b0, 1'b0);
    pop_chk("async");
    i_clk_div_select = 3'd0;
    #1;
    push(14'd0, 1'b0, 1'b1);
    pop_chk("rsttick");
    i_reset = 1'b0;

    // data 0 in CNT mode pulses every step
    i_data_from_register = 14'd0;
    i_mode = 1'b1;
    for (int k = 0; k < 5; k++)
      edge_chk("zero", 14'd0, 1'b1, 1'b1);
    i_cnt_allow = 1'b0;
    edge_chk("zerooff", 14'd0, 1'b0, 1'b1);

    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL sbdrain: got %0d exp 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
